// File: rtl/rf_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : rf_dump_reader
// Brief    : Halts the CPU and streams every register-file word out as
//            {address, data} beats over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rf_dump_reader #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rf_rr,
  input  logic [DW-1:0] rf_rd,
  output logic          cpu_halt,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          done
);

  localparam logic [AW-1:0] c_last_idx = AW'(NREG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;
  logic          r_out_valid;
  logic [AW-1:0] r_out_addr;
  logic [DW-1:0] r_out_data;
  logic          w_capture;
  logic          w_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_capture) begin
        r_out_valid <= 1'b1;
        r_out_addr  <= r_idx;
        r_out_data  <= rf_rd;
      end else if (w_drop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // abort outranks both start (in IDLE) and out_ready (in SEND)
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idx_nxt = '0;
        if (start && !abort) begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = S_SEND;
          w_capture   = 1'b1;
        end
      end
      S_SEND: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_drop      = 1'b1;
        end else if (out_ready) begin
          w_drop = 1'b1;
          if (r_idx == c_last_idx) begin
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt = S_READ;
            w_idx_nxt   = r_idx + 1'b1;
          end
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign rf_rr     = r_idx;
  assign busy      = (r_state != S_IDLE);
  assign cpu_halt  = busy;
  assign done      = (r_state == S_FIN);
  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_rf_dump_reader.sv
`default_nettype none
// Directed bench for rf_dump_reader: full-size instance plus a 4-register instance.
module tb_rf_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  rf_rr;
  logic [31:0] rf_rd;
  logic        cpu_halt, busy, out_valid, done;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic [31:0] rf [0:31];

  logic        start4 = 1'b0;
  logic        abort4 = 1'b0;
  logic        ready4 = 1'b0;
  logic [1:0]  rf_rr4;
  logic [31:0] rf_rd4;
  logic        cpu_halt4, busy4, valid4, done4;
  logic [1:0]  addr4;
  logic [31:0] data4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_rd  = rf[rf_rr];
  assign rf_rd4 = 32'hA0 + {30'd0, rf_rr4};

  rf_dump_reader #(.NREG(32), .AW(5), .DW(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rf_rr(rf_rr), .rf_rd(rf_rd), .cpu_halt(cpu_halt), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .done(done)
  );

  rf_dump_reader #(.NREG(4), .AW(2), .DW(32)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .rf_rr(rf_rr4), .rf_rd(rf_rd4), .cpu_halt(cpu_halt4), .busy(busy4),
    .out_valid(valid4), .out_ready(ready4), .out_addr(addr4),
    .out_data(data4), .done(done4)
  );

  function automatic logic [31:0] exp_data(input int k);
    return (k == 2) ? 32'h0000_0123 : 32'(k * 32'h11);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a valid beat at the given address.
  task automatic wait_beat(input int addr);
    int n;
    n = 0;
    while (!(out_valid && out_addr == 5'(addr)) && n < 200) begin
      tick();
      n++;
    end
    chk($sformatf("wait_beat_%0d_timeout", addr), 64'(n < 200), 64'd1);
  endtask

  // Full dump with out_ready high; optional spurious start pulses while busy.
  task automatic run_dump(input string name, input bit extra_starts);
    int nb, nd, nh, dcyc, ovl, bad;
    nb = 0; nd = 0; nh = 0; dcyc = -1; ovl = 0; bad = 0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      start = extra_starts && (c == 5 || c == 30 || c == 64);
      if (cpu_halt) nh++;
      if (done) begin nd++; dcyc = c; end
      if (done && out_valid) ovl++;
      if (out_valid) begin
        if (nb < 32 && (out_addr !== 5'(nb) || out_data !== exp_data(nb))) begin
          bad++;
          chk($sformatf("%s_beat%0d", name, nb), {27'd0, out_addr, out_data},
              {27'd0, 5'(nb), exp_data(nb)});
        end
        nb++;
      end
      tick();
    end
    start = 1'b0;
    chk({name, "_beats"}, 64'(nb), 64'd32);
    chk({name, "_beat_errs"}, 64'(bad), 64'd0);
    chk({name, "_done_count"}, 64'(nd), 64'd1);
    chk({name, "_done_cycle"}, 64'(dcyc), 64'd65);
    chk({name, "_halt_cycles"}, 64'(nh), 64'd65);
    chk({name, "_done_valid_overlap"}, 64'(ovl), 64'd0);
    chk({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = exp_data(k);

    // reset state
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_halt", 64'(cpu_halt), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr_data", {27'd0, out_addr, out_data}, 64'd0);
    chk("rst_rr", 64'(rf_rr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // 1: full dump, spot-check beats 2 and 31 inside
    run_dump("full", 1'b0);

    // 2: backpressure at beat 3 while reg3 changes underneath
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_beat(3);
    out_ready = 1'b0;
    rf[3] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d_addr_data", i), {27'd0, out_addr, out_data},
          {27'd0, 5'd3, 32'h33});
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("post_stall_gap", 64'(out_valid), 64'd0);
    tick();
    chk("beat4_valid", 64'(out_valid), 64'd1);
    chk("beat4_addr_data", {27'd0, out_addr, out_data}, {27'd0, 5'd4, 32'h44});
    rf[3] = exp_data(3);

    // 3: abort while presenting beat 10
    wait_beat(10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_halt", 64'(cpu_halt), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    tick();
    chk("abort_stays_idle", 64'(busy), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_rr", 64'(rf_rr), 64'd0);
    tick();
    chk("restart_first", {31'd0, out_valid, 27'd0, out_addr}, {31'd0, 1'b1, 32'd0});

    // 4: async reset between edges during beat 20
    wait_beat(20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy_halt", {62'd0, busy, cpu_halt}, 64'd0);
    chk("arst_valid_done", {62'd0, out_valid, done}, 64'd0);
    chk("arst_addr_data", {27'd0, out_addr, out_data}, 64'd0);
    chk("arst_rr", 64'(rf_rr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_release_idle", {62'd0, busy, done}, 64'd0);
    tick();
    chk("arst_release_idle2", {62'd0, busy, done}, 64'd0);

    // 5: start pulses while busy are ignored; start+abort in IDLE stays idle
    run_dump("extra", 1'b1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 64'(busy), 64'd0);
    tick();
    chk("start_abort_busy2", {62'd0, busy, out_valid}, 64'd0);

    // 6: four-register instance with out_ready toggling every cycle
    begin
      int nb4, nd4, rrbad, addrbad;
      nb4 = 0; nd4 = 0; rrbad = 0; addrbad = 0;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int c = 0; c < 40; c++) begin
        ready4 = c[0];
        #0;
        if (int'(rf_rr4) > 3) rrbad++;
        if (done4) nd4++;
        if (valid4 && ready4) begin
          if (addr4 !== 2'(nb4) || data4 !== 32'hA0 + 32'(nb4)) addrbad++;
          nb4++;
        end
        tick();
      end
      ready4 = 1'b0;
      chk("n4_beats", 64'(nb4), 64'd4);
      chk("n4_beat_errs", 64'(addrbad), 64'd0);
      chk("n4_done", 64'(nd4), 64'd1);
      chk("n4_rr_range", 64'(rrbad), 64'd0);
      chk("n4_idle", 64'(busy4), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
